// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one async_transmitter among three byte-stream requesters.
// A grant is held for a whole packet; a stalled packet is abandoned after GAP_TIMEOUT idle cycles.
module uart_tx_arbiter #(
  parameter logic [15:0] GAP_TIMEOUT = 16'd1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [23:0] req_data,
  input  logic [2:0]  req_last,
  output logic [2:0]  ack,
  output logic [2:0]  grant,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic        abort
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  // The tx_start cycle is the first of the two guard cycles, so only one WAIT cycle is loaded.
  localparam int unsigned GUARD_CYCLES = 2;
  localparam logic [1:0]  GUARD_LOAD   = 2'(GUARD_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [2:0]  grant_reg, grant_next;
  logic [1:0]  owner_reg, owner_next;
  logic [1:0]  last_owner_reg, last_owner_next;
  logic        last_flag_reg, last_flag_next;
  logic [15:0] gap_reg, gap_next;
  logic [1:0]  guard_reg, guard_next;
  logic [7:0]  data_reg, data_next;

  logic [7:0]  req_byte [3];
  logic [7:0]  sel_byte;
  logic        owner_req, owner_last, send_fire;
  logic        pick_valid;
  logic [1:0]  pick_idx, cand;

  for (genvar gi = 0; gi < 3; gi++) begin : g_slice
    assign req_byte[gi] = req_data[8*gi +: 8];
  end

  assign owner_req  = |(req & grant_reg);
  assign owner_last = |(req_last & grant_reg);
  assign send_fire  = (state_reg == SEND) && owner_req;

  always_comb begin
    sel_byte = '0;
    for (int k = 0; k < 3; k++) begin
      sel_byte = sel_byte | (req_byte[k] & {8{grant_reg[k]}});
    end
  end

  // Round-robin search starting just after the previous owner.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = 2'd0;
    cand       = (last_owner_reg == 2'd2) ? 2'd0 : last_owner_reg + 2'd1;
    for (int k = 0; k < 3; k++) begin
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
    end
  end

  // The byte is forwarded straight through on the start cycle, then held by data_reg.
  assign tx_start = send_fire;
  assign ack      = send_fire ? grant_reg : 3'b000;
  assign tx_data  = send_fire ? sel_byte : data_reg;
  assign abort    = (state_reg == SEND) && !owner_req && (gap_reg == GAP_TIMEOUT - 16'd1);
  assign grant    = grant_reg;

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    last_flag_next  = last_flag_reg;
    gap_next        = gap_reg;
    guard_next      = guard_reg;
    data_next       = data_reg;
    case (state_reg)
      IDLE: begin
        grant_next = 3'b000;
        gap_next   = '0;
        if (pick_valid) begin
          grant_next = 3'b001 << pick_idx;
          owner_next = pick_idx;
          state_next = SEND;
        end
      end
      SEND: begin
        if (owner_req) begin
          data_next      = sel_byte;
          last_flag_next = owner_last;
          gap_next       = '0;
          guard_next     = GUARD_LOAD;
          state_next     = WAIT;
        end else if (gap_reg == GAP_TIMEOUT - 16'd1) begin
          grant_next      = 3'b000;
          last_owner_next = owner_reg;
          gap_next        = '0;
          state_next      = IDLE;
        end else begin
          gap_next = gap_reg + 16'd1;
        end
      end
      WAIT: begin
        if (guard_reg != 2'd0) begin
          guard_next = guard_reg - 2'd1;
        end else if (!tx_busy) begin
          if (last_flag_reg) begin
            grant_next      = 3'b000;
            last_owner_next = owner_reg;
            state_next      = IDLE;
          end else begin
            state_next = SEND;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      grant_reg      <= 3'b000;
      owner_reg      <= 2'd0;
      last_owner_reg <= 2'd2;
      last_flag_reg  <= 1'b0;
      gap_reg        <= '0;
      guard_reg      <= 2'd0;
      data_reg       <= 8'h00;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      last_flag_reg  <= last_flag_next;
      gap_reg        <= gap_next;
      guard_reg      <= guard_next;
      data_reg       <= data_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued requester model, busy model and negedge monitor.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [23:0] req_data = 24'h0;
  logic [2:0]  req_last = 3'b000;
  logic        tx_busy = 1'b0;
  logic [2:0]  ack, grant;
  logic        tx_start, abort;
  logic [7:0]  tx_data;

  uart_tx_arbiter #(.GAP_TIMEOUT(16'd8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .grant(grant), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .abort(abort)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Requester queues hold {last, byte}; en gates whether each requester asserts req.
  logic [8:0] q0[$], q1[$], q2[$];
  logic [2:0] en = 3'b000;

  bit  busy_en = 1'b0;
  int  busy_cnt = 0;
  int  cyc = 0;
  int  n_start = 0, n_abort = 0, abort_cyc = 0, viol = 0;
  int  n_ack [3];
  logic [7:0] log_data[$];
  logic [2:0] log_grant[$];
  int         log_cyc[$];
  logic       prev_start = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ld(input int i);
    return (i < log_data.size()) ? log_data[i] : 8'hxx;
  endfunction
  function automatic logic [2:0] lg(input int i);
    return (i < log_grant.size()) ? log_grant[i] : 3'bxxx;
  endfunction
  function automatic int lc(input int i);
    return (i < log_cyc.size()) ? log_cyc[i] : -1000;
  endfunction

  // Monitor and busy model: tx_busy high for 24 cycles starting one cycle after tx_start.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (busy_cnt > 0) begin tx_busy = 1'b1; busy_cnt--; end
    else tx_busy = 1'b0;
    if (rst_n) begin
      if (tx_start) begin
        n_start++;
        log_data.push_back(tx_data);
        log_grant.push_back(grant);
        log_cyc.push_back(cyc);
        if (busy_en) busy_cnt = 24;
      end else if (log_data.size() > 0 && tx_data !== log_data[log_data.size()-1]) begin
        viol++;
      end
      if (tx_start && prev_start) viol++;
      if ((ack & ~grant) != 3'b000 || $countones(ack) > 1) viol++;
      if (abort) begin n_abort++; abort_cyc = cyc; end
      for (int i = 0; i < 3; i++) if (ack[i]) n_ack[i]++;
      if (ack[0] && q0.size() > 0) void'(q0.pop_front());
      if (ack[1] && q1.size() > 0) void'(q1.pop_front());
      if (ack[2] && q2.size() > 0) void'(q2.pop_front());
    end
    prev_start = tx_start && rst_n;
  end

  task automatic drive();
    logic [8:0] h0, h1, h2;
    h0 = (q0.size() > 0) ? q0[0] : 9'h0;
    h1 = (q1.size() > 0) ? q1[0] : 9'h0;
    h2 = (q2.size() > 0) ? q2[0] : 9'h0;
    req      = en & {q2.size() > 0, q1.size() > 0, q0.size() > 0};
    req_data = {h2[7:0], h1[7:0], h0[7:0]};
    req_last = {h2[8], h1[8], h0[8]};
  endtask

  task automatic step();
    @(posedge clk); #1;
    drive();
    #1;
  endtask

  task automatic clear_stats();
    n_start = 0; n_abort = 0; abort_cyc = 0;
    for (int i = 0; i < 3; i++) n_ack[i] = 0;
    log_data.delete(); log_grant.delete(); log_cyc.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    en = 3'b000; busy_en = 1'b0; busy_cnt = 0;
    q0.delete(); q1.delete(); q2.delete();
    drive();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_stats();
    #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) n_ack[i] = 0;
    // Reset state
    drive();
    repeat (3) @(posedge clk);
    #2;
    check("rst_grant", grant, 3'b000);
    check("rst_ack", ack, 3'b000);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_abort", abort, 1'b0);
    #1 rst_n = 1'b1;

    // Two-byte packet from requester 0 with 24-cycle busy
    clear_stats(); busy_en = 1'b1;
    q0.push_back({1'b0, 8'h61}); q0.push_back({1'b1, 8'h62}); en = 3'b001;
    for (int c = 0; c < 200 && !(n_start == 2 && grant == 3'b000); c++) step();
    check("t1_complete", (n_start == 2 && grant == 3'b000), 1'b1);
    check("t1_starts", n_start, 2);
    check("t1_byte0", ld(0), 8'h61);
    check("t1_byte1", ld(1), 8'h62);
    check("t1_grant0", lg(0), 3'b001);
    check("t1_grant1", lg(1), 3'b001);
    check("t1_ack0", n_ack[0], 2);
    check("t1_spacing", lc(1) - lc(0), 26);
    repeat (5) step();
    check("t1_idle_grant", grant, 3'b000);

    // All three requesting single-byte packets
    do_reset();
    q0.push_back({1'b1, 8'hA0}); q0.push_back({1'b1, 8'hA1});
    q1.push_back({1'b1, 8'hB0}); q1.push_back({1'b1, 8'hB1});
    q2.push_back({1'b1, 8'hC0}); q2.push_back({1'b1, 8'hC1});
    en = 3'b111;
    for (int c = 0; c < 100 && n_start < 4; c++) step();
    en = 3'b000;
    check("t2_starts", n_start, 4);
    check("t2_g0", lg(0), 3'b001);
    check("t2_g1", lg(1), 3'b010);
    check("t2_g2", lg(2), 3'b100);
    check("t2_g3", lg(3), 3'b001);
    check("t2_d0", ld(0), 8'hA0);
    check("t2_d3", ld(3), 8'hA1);
    check("t2_ack1", n_ack[1], 1);
    check("t2_period", lc(3) - lc(0), 12);
    repeat (10) step();
    check("t2_no_more", n_start, 4);
    check("t2_grant_idle", grant, 3'b000);

    // Requester 0 arrives mid-packet of requester 1
    do_reset();
    q1.push_back({1'b0, 8'h11}); q1.push_back({1'b0, 8'h12}); q1.push_back({1'b1, 8'h13});
    en = 3'b010;
    for (int c = 0; c < 50 && n_start < 1; c++) step();
    q0.push_back({1'b1, 8'h01}); en = 3'b011;
    for (int c = 0; c < 100 && n_start < 4; c++) step();
    check("t3_starts", n_start, 4);
    check("t3_d2", ld(2), 8'h13);
    check("t3_g2", lg(2), 3'b010);
    check("t3_d3", ld(3), 8'h01);
    check("t3_g3", lg(3), 3'b001);
    check("t3_ack0", n_ack[0], 1);

    // Gap timeout (GAP_TIMEOUT=8) after a non-last byte from requester 2
    do_reset();
    q2.push_back({1'b0, 8'h21}); en = 3'b100;
    for (int c = 0; c < 60 && n_abort < 1; c++) step();
    check("t4_abort_seen", n_abort, 1);
    check("t4_abort_time", abort_cyc - lc(0), 10);
    check("t4_grant", lg(0), 3'b100);
    repeat (20) step();
    check("t4_abort_once", n_abort, 1);
    check("t4_no_start", n_start, 1);
    check("t4_grant_idle", grant, 3'b000);

    // Busy never asserted: 3-cycle byte spacing
    clear_stats(); en = 3'b000;
    q0.push_back({1'b0, 8'h31}); q0.push_back({1'b0, 8'h32}); q0.push_back({1'b1, 8'h33});
    en = 3'b001;
    for (int c = 0; c < 50 && n_start < 3; c++) step();
    check("t5_starts", n_start, 3);
    check("t5_gap01", lc(1) - lc(0), 3);
    check("t5_gap12", lc(2) - lc(1), 3);
    check("t5_d2", ld(2), 8'h33);
    for (int c = 0; c < 20 && grant != 3'b000; c++) step();
    check("t5_grant_idle", grant, 3'b000);

    // Asynchronous reset during WAIT
    do_reset();
    busy_en = 1'b1;
    q0.push_back({1'b0, 8'h71}); q0.push_back({1'b1, 8'h72}); en = 3'b001;
    for (int c = 0; c < 50 && n_start < 1; c++) step();
    step();
    check("t6_pre_data", tx_data, 8'h71);
    check("t6_pre_grant", grant, 3'b001);
    rst_n = 1'b0;
    #1;
    check("t6_async_grant", grant, 3'b000);
    check("t6_async_data", tx_data, 8'h00);
    check("t6_async_start", tx_start, 1'b0);
    check("t6_async_abort", abort, 1'b0);
    check("t6_no_abort", n_abort, 0);
    en = 3'b000; busy_en = 1'b0; busy_cnt = 0;
    q0.delete();
    drive();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_stats();
    q1.push_back({1'b1, 8'h81}); q2.push_back({1'b1, 8'h91}); en = 3'b110;
    for (int c = 0; c < 50 && n_start < 1; c++) step();
    check("t6_first_grant", lg(0), 3'b010);
    check("t6_first_data", ld(0), 8'h81);
    en = 3'b000;
    repeat (20) step();

    check("protocol_violations", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter GAP_TIMEOUT, default 16'd1000, meaning the idle cycles allowed mid-packet before the grant is revoked.
REQ-002 SHALL have port clk, input, 1 bit: the single clock (10 MHz CLK_SE_AR domain).
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port req, input, 3 bits: per-requester "byte available".
REQ-005 SHALL have port req_data, input, 24 bits: byte of requester i on bits [8i+7:8i].
REQ-006 SHALL have port req_last, input, 3 bits: presented byte is the last of its packet.
REQ-007 SHALL have port ack, output, 3 bits: one-cycle pulse, byte of requester i consumed.
REQ-008 SHALL have port grant, output, 3 bits: one-hot owner of the transmitter, 0 when idle.
REQ-009 SHALL have port tx_start, output, 1 bit: one-cycle start pulse to async_transmitter TxD_start.
REQ-010 SHALL have port tx_data, output, 8 bits: byte to async_transmitter TxD_data.
REQ-011 SHALL have port tx_busy, input, 1 bit: from async_transmitter TxD_busy.
REQ-012 SHALL have port abort, output, 1 bit: one-cycle pulse, packet abandoned on gap timeout.

Function
REQ-013 SHALL implement states IDLE, SEND, WAIT.
REQ-014 In IDLE with req!=0, SHALL choose a winner round-robin, searching from (last_owner+1) mod 3, then set grant one-hot and enter SEND on the next edge.
REQ-015 In IDLE with req==0, SHALL hold grant=0 and remain in IDLE.
REQ-016 In SEND with req[g]=1, SHALL, in the same cycle, pulse tx_start=1 and ack[g]=1, register tx_data<=req_data[g], register last_flag<=req_last[g], clear the gap counter, and enter WAIT.
REQ-017 In SEND with req[g]=0, SHALL increment the gap counter.
REQ-018 When the gap counter reaches GAP_TIMEOUT-1 with req[g] still 0, SHALL pulse abort, clear grant, record last_owner=g, and enter IDLE.
REQ-019 On entering WAIT, SHALL load a 2-cycle guard counter.
REQ-020 SHALL ignore tx_busy while the guard counter is nonzero, covering the transmitter's busy-assert latency.
REQ-021 In WAIT with guard==0 and tx_busy==0 and last_flag=1, SHALL clear grant, record last_owner=g, and enter IDLE.
REQ-022 In WAIT with guard==0 and tx_busy==0 and last_flag=0, SHALL return to SEND, keeping the grant.
REQ-023 SHALL hold tx_data stable from the tx_start cycle until the next tx_start.
REQ-024 tx_start SHALL never be high in consecutive cycles.
REQ-025 ack SHALL be 0 outside SEND.
REQ-026 At most one ack bit SHALL be high in any cycle, and only the bit matching grant.
REQ-027 Grant SHALL NOT change mid-packet; requesters other than g are ignored until IDLE.
REQ-028 Changes in req of non-granted requesters during SEND or WAIT SHALL have no effect.
REQ-029 A single-byte packet (req_last=1 on the first byte) SHALL be legal.
REQ-030 Back-to-back packets from the same sole requester SHALL be allowed, with one IDLE cycle between them.
REQ-031 Minimum per-byte overhead SHALL be 1 SEND cycle plus the 2-cycle guard, beyond the transmitter's busy time.

Reset
REQ-032 While rst_n=0, SHALL force state=IDLE, grant=0, ack=0, tx_start=0, tx_data=8'h00, abort=0, gap and guard counters=0, last_owner=2 (so requester 0 wins first), last_flag=0.
REQ-033 Reset asserted mid-packet SHALL abandon the packet with no abort pulse; after release, arbitration SHALL restart from requester 0.

Verification
REQ-034 Bench: req=3'b001, packet 8'h61,8'h62 (last on 2nd), tx_busy modelled as 24 cycles starting 1 cycle after tx_start -> exactly two tx_start pulses, tx_data 8'h61 then 8'h62, ack[0] twice, grant=3'b001 throughout, then 3'b000.
REQ-035 Bench: req=3'b111 held, single-byte packets -> grant sequence 001,010,100,001, one byte each.
REQ-036 Bench: requester 1 granted; requester 0 raises req mid-packet -> requester 0 not acked until requester 1's last byte completes.
REQ-037 Bench: GAP_TIMEOUT=8; requester 2 sends one non-last byte, then drops req -> abort pulses once, 8 cycles into SEND, grant returns to 0, no further tx_start.
REQ-038 Bench: tx_busy held 0 permanently -> tx_start spacing exactly 3 cycles for a 3-byte packet.
REQ-039 Bench: rst_n pulsed low during WAIT -> outputs reach reset values asynchronously; with req=3'b110 after release, grant=3'b010 first.
